// File: rtl/spart_pkg.sv
// Shared definitions for the SPART receiver: FSM states, oversampling constants, baud table.
package spart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SubW       = $clog2(OVERSAMPLE);

  // Sub-tick indices used by the three-sample majority vote; the decision is taken on the last.
  localparam logic [SubW-1:0] SAMPLE_A = SubW'(7);
  localparam logic [SubW-1:0] SAMPLE_B = SubW'(8);
  localparam logic [SubW-1:0] SAMPLE_C = SubW'(9);

  // Default clocks per oversample tick for each br_cfg setting.
  function automatic int unsigned default_div(input logic [1:0] br_cfg);
    int unsigned div;
    unique case (br_cfg)
      2'b00:   div = 651;
      2'b01:   div = 326;
      2'b10:   div = 163;
      default: div = 81;
    endcase
    return div;
  endfunction

endpackage

// File: rtl/spart_sync_fifo.sv
// First-word-fall-through FIFO; the head is registered so it holds its last value when empty.
module spart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_ptr_nx;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign rd_valid  = (count_q != '0);
  assign full      = (count_q == FullCnt);
  assign do_pop    = rd_en && rd_valid;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign do_push   = wr_en && (!full || do_pop);
  assign rd_ptr_nx = rd_ptr_q + AW'(1);
  assign rd_data   = head_q;
  assign count     = count_q;

  // Storage array; pointer reset makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Next head value: the following entry after a pop, or the incoming word when it becomes head.
  always_comb begin
    head_d = head_q;
    if (do_pop) begin
      if (count_q > CW'(1)) head_d = mem_q[rd_ptr_nx];
      else if (do_push)     head_d = wr_data;
    end else if (do_push && (count_q == '0)) begin
      head_d = wr_data;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_nx;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
      head_q  <= head_d;
    end
  end

endmodule

// File: rtl/spart_rx_fifo.sv
// SPART receiver: 16x oversampled, majority-voted UART rx with parity/framing checks and a FIFO.
module spart_rx_fifo
  import spart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV0       = default_div(2'b00),
  parameter int unsigned DIV1       = default_div(2'b01),
  parameter int unsigned DIV2       = default_div(2'b10),
  parameter int unsigned DIV3       = default_div(2'b11)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    br_cfg,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  output logic                          parity_err,
  output logic                          framing_err,
  input  logic                          clr_err
);

  localparam int unsigned CntW = 16;
  localparam int unsigned BitW = 4;

  logic                 sync1_q, rxs_q;
  logic [CntW-1:0]      div_m1, tick_cnt_q;
  logic                 tick;
  rx_state_e            state_q;
  logic [SubW-1:0]      sub_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bad_q;
  logic                 s7_q, s8_q, vote, decide;
  logic                 stop_decide, good, push, fifo_full;
  logic                 overrun_q, parity_err_q, framing_err_q;

  // Two-flop synchroniser on the asynchronous line, idle-high at reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxs_q   <= sync1_q;
    end
  end

  // Reload value for the selected baud; sampled only at reload so changes never glitch a tick.
  always_comb begin
    div_m1 = CntW'(DIV3 - 1);
    unique case (br_cfg)
      2'b00:   div_m1 = CntW'(DIV0 - 1);
      2'b01:   div_m1 = CntW'(DIV1 - 1);
      2'b10:   div_m1 = CntW'(DIV2 - 1);
      default: div_m1 = CntW'(DIV3 - 1);
    endcase
  end

  assign tick = (tick_cnt_q == '0);

  // Oversample tick down-counter.
  always_ff @(posedge clk) begin
    if (!rst)      tick_cnt_q <= div_m1;
    else if (tick) tick_cnt_q <= div_m1;
    else           tick_cnt_q <= tick_cnt_q - CntW'(1);
  end

  assign vote   = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);
  assign decide = tick && (sub_q == SAMPLE_C);

  // Receive FSM; the tick that detects the start edge counts as sub-tick 0 of the start bit.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      sub_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      s7_q      <= 1'b1;
      s8_q      <= 1'b1;
    end else begin
      if (tick && (sub_q == SAMPLE_A)) s7_q <= rxs_q;
      if (tick && (sub_q == SAMPLE_B)) s8_q <= rxs_q;
      unique case (state_q)
        StIdle: begin
          sub_q     <= '0;
          bit_cnt_q <= '0;
          par_bad_q <= 1'b0;
          if (tick && !rxs_q) begin
            state_q <= StStart;
            sub_q   <= SubW'(1);
          end
        end
        StStart: begin
          if (tick)   sub_q   <= sub_q + SubW'(1);
          if (decide) state_q <= vote ? StIdle : StData;
        end
        StData: begin
          if (tick) sub_q <= sub_q + SubW'(1);
          if (decide) begin
            shift_q   <= {vote, shift_q[DATA_BITS-1:1]};
            bit_cnt_q <= bit_cnt_q + BitW'(1);
            if (bit_cnt_q == BitW'(DATA_BITS - 1)) begin
              state_q <= (PARITY_EN != 0) ? StParity : StStop;
            end
          end
        end
        StParity: begin
          if (tick) sub_q <= sub_q + SubW'(1);
          if (decide) begin
            par_bad_q <= vote ^ (^shift_q) ^ (PARITY_ODD != 0);
            state_q   <= StStop;
          end
        end
        StStop: begin
          if (tick)   sub_q   <= sub_q + SubW'(1);
          if (decide) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Disposal of a finished word: framing beats parity, parity beats push.
  assign stop_decide = decide && (state_q == StStop);
  assign good        = stop_decide && vote && !par_bad_q;
  assign push        = good && (!fifo_full || rd_en);

  // Sticky error flags; a set in the same cycle as clr_err wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overrun_q     <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      if (stop_decide && !vote)              framing_err_q <= 1'b1;
      else if (clr_err)                      framing_err_q <= 1'b0;
      if (stop_decide && vote && par_bad_q)  parity_err_q  <= 1'b1;
      else if (clr_err)                      parity_err_q  <= 1'b0;
      if (good && fifo_full && !rd_en)       overrun_q     <= 1'b1;
      else if (clr_err)                      overrun_q     <= 1'b0;
    end
  end

  assign overrun     = overrun_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;

  spart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (push),
    .wr_data  (shift_q),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (fifo_count),
    .full     (fifo_full)
  );

endmodule
